nor_seq_ctrl: RTL and testbench
===============================

Name: nor_seq_ctrl

Overview:
- Sequencer that time-shares one WIDTH-bit NOR unit to evaluate any 2-input bitwise function, one NOR step per clock.
- Each opcode maps to a fixed micro-program of NOR steps over a small scratch register file.
- Start/busy/done handshake. Sits beside the gate library as the controller for the universal-NOR datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- op  in  3  function select: 0 NOR, 1 OR, 2 NOT(a), 3 AND, 4 NAND, 5 XNOR, 6 XOR, 7 BUF(a).
- a  in  WIDTH  operand A. Captured on accept.
- b  in  WIDTH  operand B. Captured on accept.
- busy  out  1  high while a micro-program executes.
- done  out  1  one-cycle pulse; result valid from this cycle on.
- result  out  WIDTH  last completed result. Held until the next completion.
- steps  out  3  NOR step count of the last completed op.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, steps=0; operand regs, scratch T0..T2 and step counter cleared.
- State IDLE:
  - start=1 -> capture a, b, op into RA, RB, ROP; clear step counter; go to EXEC.
  - start=0 -> hold.
- State EXEC: each edge performs one micro-instruction T[dst] <= ~(src1 | src2), then increments the step counter.
  - src is one of RA, RB, T0, T1, T2.
  - On the last step: result <= NOR output, steps <= N, done <= 1, go to IDLE.
- busy: registered. High from the edge after start is accepted through the last EXEC cycle. Low in the cycle where done=1.
- Latency: the start-sampling edge loads operands. done is high in the cycle after the N-th following edge. A back-to-back start while done=1 is accepted (state is IDLE).
- start while busy: ignored, no queuing. Changes on a/b/op during busy: no effect.
- Micro-programs (N steps; the last destination is the result):
  - NOR (N=1): T0=NOR(A,B).
  - OR (N=2): T0=NOR(A,B); T0=NOR(T0,T0).
  - NOT (N=1): T0=NOR(A,A).
  - BUF (N=2): T0=NOR(A,A); T0=NOR(T0,T0).
  - AND (N=3): T0=NOR(A,A); T1=NOR(B,B); T0=NOR(T0,T1).
  - NAND (N=4): AND sequence + T0=NOR(T0,T0).
  - XNOR (N=4): T0=NOR(A,B); T1=NOR(A,T0); T2=NOR(B,T0); T0=NOR(T1,T2).
  - XOR (N=5): XNOR sequence + T0=NOR(T0,T0).
- All arithmetic is bitwise, WIDTH-wide; no carries. The step counter is 3 bits; max N=5, so no wrap.
- Reset asserted mid-EXEC: abort immediately; no done; result returns to 0.

Decomposition:
- Package nor_seq_pkg:
  - op_e enum (3-bit, codes above).
  - src_e enum (RA, RB, T0, T1, T2).
  - dst_e enum (T0..T2).
  - micro_t struct {src1, src2, dst}.
  - Constant STEP_N[op].
  - Function micro(op, step) returning micro_t (the ROM).
- Sub-module nor_vec: WIDTH-parameterised combinational y = ~(x1 | x2). Exactly one instance, driven by the src muxes.
- Controller: FSM + operand/scratch registers + step counter.

Test Plan (WIDTH=8, a=8'hCA, b=8'hA5 unless noted):
- Each op 0..7 issued singly:
  - result = 10, EF, 35, 80, 7F, 90, 6F, CA respectively.
  - steps = 1, 2, 1, 3, 4, 4, 5, 2.
  - done exactly N cycles after the start edge.
  - busy high for exactly N-1 cycles (0 for N=1).
- XOR started, then a=00 / b=FF / start=1 / op=0 driven during busy -> ignored; result=6F, steps=5; no second done.
- Back-to-back: AND, then NOR with start=1 held in the done cycle -> second op accepted; done pulses at cycles 3 and 3+1+1; results 80 then 10.
- rst_n pulsed low during step 2 of NAND -> busy/done/result/steps = 0 immediately. After release, a NOT op completes with result=35.
- Exhaustive: WIDTH=1, all 8 ops x 4 (a,b) combos vs. reference truth table -> all match.
- start held low for 20 cycles after reset -> busy=0, done=0, result=00 throughout.

Source files
------------

// File: rtl/nor_seq_pkg.sv
// Shared types and micro-program ROM for the NOR sequencer.
package nor_seq_pkg;

    typedef enum logic [2:0] {
        OpNor  = 3'd0,
        OpOr   = 3'd1,
        OpNot  = 3'd2,
        OpAnd  = 3'd3,
        OpNand = 3'd4,
        OpXnor = 3'd5,
        OpXor  = 3'd6,
        OpBuf  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        SrcRa = 3'd0,
        SrcRb = 3'd1,
        SrcT0 = 3'd2,
        SrcT1 = 3'd3,
        SrcT2 = 3'd4
    } src_e;

    typedef enum logic [1:0] {
        DstT0 = 2'd0,
        DstT1 = 2'd1,
        DstT2 = 2'd2
    } dst_e;

    typedef struct packed {
        src_e src1;
        src_e src2;
        dst_e dst;
    } micro_t;

    // Number of NOR steps per opcode, indexed by op code.
    localparam logic [2:0] STEP_N [0:7] = '{
        3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5, 3'd2
    };

    // Micro-program ROM: instruction executed at a given step of an opcode.
    function automatic micro_t micro(input op_e op, input logic [2:0] step);
        micro_t m;
        m = '{src1: SrcRa, src2: SrcRb, dst: DstT0};
        case (op)
            OpNor: ;
            OpOr: begin
                if (step == 3'd1) m = '{src1: SrcT0, src2: SrcT0, dst: DstT0};
            end
            OpNot: m = '{src1: SrcRa, src2: SrcRa, dst: DstT0};
            OpBuf: begin
                if (step == 3'd0) m = '{src1: SrcRa, src2: SrcRa, dst: DstT0};
                else              m = '{src1: SrcT0, src2: SrcT0, dst: DstT0};
            end
            OpAnd, OpNand: begin
                case (step)
                    3'd0:    m = '{src1: SrcRa, src2: SrcRa, dst: DstT0};
                    3'd1:    m = '{src1: SrcRb, src2: SrcRb, dst: DstT1};
                    3'd2:    m = '{src1: SrcT0, src2: SrcT1, dst: DstT0};
                    default: m = '{src1: SrcT0, src2: SrcT0, dst: DstT0};
                endcase
            end
            OpXnor, OpXor: begin
                case (step)
                    3'd0:    m = '{src1: SrcRa, src2: SrcRb, dst: DstT0};
                    3'd1:    m = '{src1: SrcRa, src2: SrcT0, dst: DstT1};
                    3'd2:    m = '{src1: SrcRb, src2: SrcT0, dst: DstT2};
                    3'd3:    m = '{src1: SrcT1, src2: SrcT2, dst: DstT0};
                    default: m = '{src1: SrcT0, src2: SrcT0, dst: DstT0};
                endcase
            end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nor_seq_ctrl_nor_vec.sv
// Combinational WIDTH-bit NOR unit shared by every micro-instruction.
module nor_vec #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y
);

    assign y = ~(x1 | x2);

endmodule

// File: rtl/nor_seq_ctrl.sv
// Sequencer evaluating any 2-input bitwise function with one shared NOR unit,
// one NOR step per clock, with a start/busy/done handshake.
module nor_seq_ctrl
    import nor_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       steps
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q, state_d;
    op_e              rop_q, rop_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [WIDTH-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
    logic [2:0]       step_q, step_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       steps_q, steps_d;

    micro_t           uinst;
    logic [2:0]       step_n;
    logic             last_step;
    logic [WIDTH-1:0] nor_x1, nor_x2, nor_y;

    // Decode the current micro-instruction and whether it is the final one.
    always_comb begin
        uinst     = micro(rop_q, step_q);
        step_n    = STEP_N[rop_q];
        last_step = (step_q == step_n - 3'd1);
    end

    // Route the two selected sources into the shared NOR unit.
    always_comb begin
        nor_x1 = '0;
        nor_x2 = '0;
        case (uinst.src1)
            SrcRa:   nor_x1 = ra_q;
            SrcRb:   nor_x1 = rb_q;
            SrcT0:   nor_x1 = t0_q;
            SrcT1:   nor_x1 = t1_q;
            SrcT2:   nor_x1 = t2_q;
            default: nor_x1 = '0;
        endcase
        case (uinst.src2)
            SrcRa:   nor_x2 = ra_q;
            SrcRb:   nor_x2 = rb_q;
            SrcT0:   nor_x2 = t0_q;
            SrcT1:   nor_x2 = t1_q;
            SrcT2:   nor_x2 = t2_q;
            default: nor_x2 = '0;
        endcase
    end

    nor_vec #(
        .WIDTH(WIDTH)
    ) u_nor (
        .x1(nor_x1),
        .x2(nor_x2),
        .y (nor_y)
    );

    // Next-state: accept in idle, execute one NOR step per cycle in exec.
    always_comb begin
        state_d  = state_q;
        rop_d    = rop_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        t0_d     = t0_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        step_d   = step_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        steps_d  = steps_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    rop_d   = op_e'(op);
                    step_d  = 3'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                case (uinst.dst)
                    DstT0:   t0_d = nor_y;
                    DstT1:   t1_d = nor_y;
                    DstT2:   t2_d = nor_y;
                    default: t0_d = nor_y;
                endcase
                step_d = step_q + 3'd1;
                if (last_step) begin
                    result_d = nor_y;
                    steps_d  = step_n;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else begin
                    // Busy only rises on the first exec edge, so it covers N-1 cycles.
                    busy_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any program in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rop_q    <= OpNor;
            ra_q     <= '0;
            rb_q     <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            step_q   <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            steps_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            rop_q    <= rop_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            steps_q  <= steps_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_nor_seq_ctrl.sv
// Directed self-checking bench for nor_seq_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_nor_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done;
    logic [7:0] result;
    logic [2:0] steps;

    logic       start1 = 1'b0;
    logic [2:0] op1 = 3'd0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       busy1, done1;
    logic       result1;
    logic [2:0] steps1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nor_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .steps(steps)
    );

    nor_seq_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .steps(steps1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Truth table of each opcode for the WIDTH=1 sweep.
    function automatic logic ref_fn(input logic [2:0] o, input logic x, input logic y);
        case (o)
            3'd0:    return !(x || y);
            3'd1:    return x || y;
            3'd2:    return !x;
            3'd3:    return x && y;
            3'd4:    return !(x && y);
            3'd5:    return x == y;
            3'd6:    return x != y;
            default: return x;
        endcase
    endfunction

    // Drive a request for one cycle; returns at the negedge after the accepting edge (k=0).
    task automatic launch(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From k=0, sample each negedge until done; bounded.
    task automatic wait_done(output int done_at, output int busy_n);
        done_at = -1;
        busy_n  = 0;
        for (int k = 0; k < 16; k++) begin
            if (done) begin
                done_at = k;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    logic [7:0] exp_res [0:7] = '{8'h10, 8'hEF, 8'h35, 8'h80, 8'h7F, 8'h90, 8'h6F, 8'hCA};
    logic [2:0] exp_n   [0:7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5, 3'd2};

    initial begin
        int done_at, busy_n, n_done;
        int dcyc [2];
        logic [7:0] dres [2];

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_steps", steps, 0);
        check("rst_result_w1", result1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_result", result, 0);
        end

        // Each opcode singly
        for (int o = 0; o < 8; o++) begin
            launch(3'(o), 8'hCA, 8'hA5);
            wait_done(done_at, busy_n);
            check($sformatf("op%0d_done_cycle", o), done_at, exp_n[o]);
            check($sformatf("op%0d_busy_cycles", o), busy_n, exp_n[o] - 1);
            check($sformatf("op%0d_busy_at_done", o), busy, 0);
            check($sformatf("op%0d_result", o), result, exp_res[o]);
            check($sformatf("op%0d_steps", o), steps, exp_n[o]);
            @(negedge clk);
            check($sformatf("op%0d_done_pulse", o), done, 0);
        end

        // XOR with disturbing inputs during busy
        launch(3'd6, 8'hCA, 8'hA5);
        a = 8'h00; b = 8'hFF; op = 3'd0; start = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) start = 1'b0;
            if (done) begin
                n_done++;
                check("xor_busy_result", result, 8'h6F);
                check("xor_busy_steps", steps, 5);
                check("xor_busy_cycle", k, 5);
            end
            @(negedge clk);
        end
        check("xor_busy_done_count", n_done, 1);

        // Back-to-back: AND then NOR accepted in the done cycle
        a = 8'hCA; b = 8'hA5;
        launch(3'd3, 8'hCA, 8'hA5);
        start = 1'b1; op = 3'd0;
        n_done = 0;
        dcyc[0] = -1; dcyc[1] = -1; dres[0] = 8'h00; dres[1] = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) start = 1'b0;
            if (done) begin
                if (n_done < 2) begin
                    dcyc[n_done] = k;
                    dres[n_done] = result;
                end
                n_done++;
            end
            @(negedge clk);
        end
        check("b2b_done_count", n_done, 2);
        check("b2b_first_cycle", dcyc[0], 3);
        check("b2b_first_result", dres[0], 8'h80);
        check("b2b_second_cycle", dcyc[1], 5);
        check("b2b_second_result", dres[1], 8'h10);

        // Reset during step 2 of NAND
        launch(3'd4, 8'hCA, 8'hA5);
        check("nand_busy_before_rst", busy, 0);
        @(negedge clk);
        check("nand_busy_step2", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_steps", steps, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        launch(3'd2, 8'hCA, 8'hA5);
        wait_done(done_at, busy_n);
        check("post_rst_not_cycle", done_at, 1);
        check("post_rst_not_result", result, 8'h35);

        // WIDTH=1 sweep
        for (int o = 0; o < 8; o++) begin
            for (int v = 0; v < 4; v++) begin
                logic [1:0] ab;
                int got_at;
                ab = 2'(v);
                @(negedge clk);
                start1 = 1'b1; op1 = 3'(o); a1 = ab[1]; b1 = ab[0];
                @(negedge clk);
                start1 = 1'b0;
                got_at = -1;
                for (int k = 0; k < 16; k++) begin
                    if (done1) begin
                        got_at = k;
                        break;
                    end
                    @(negedge clk);
                end
                check($sformatf("w1_op%0d_ab%0d_done", o, v), got_at, exp_n[o]);
                check($sformatf("w1_op%0d_ab%0d_result", o, v), result1,
                      ref_fn(3'(o), ab[1], ab[0]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
